// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory wait timeout, illegal-instruction trap and retired-instruction counter.
module riscv_multicycle_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        pc_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        retire,
  output logic [31:0] instret,
  output logic        illegal,
  output logic        timeout
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | instruction read, waiting for mem_ready
  // DECODE| legality check of the latched instruction
  // EXECUTE| ALU work; branches retire here
  // MEMORY| load/store access; stores retire here
  // WRITEBACK| register write, PC update, retire
  // TRAP  | absorbing error state until reset
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        st;
  logic [CW-1:0] wait_cnt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       unused_rs_bits;

  assign opcode         = instr[6:0];
  assign funct3         = instr[14:12];
  assign funct7         = instr[31:25];
  assign rd             = instr[11:7];
  assign unused_rs_bits = ^instr[24:15];

  logic is_reg, is_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  assign is_reg    = (opcode == 7'b0110011);
  assign is_imm    = (opcode == 7'b0010011);
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_branch = (opcode == 7'b1100011);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111);
  assign is_lui    = (opcode == 7'b0110111);
  assign is_auipc  = (opcode == 7'b0010111);

  logic bad_instr;
  always_comb begin
    bad_instr = 1'b0;
    if (is_load)
      bad_instr = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    else if (is_store)
      bad_instr = (funct3 > 3'd2);
    else if (is_branch)
      bad_instr = (funct3 == 3'd2) || (funct3 == 3'd3);
    else if (is_jalr)
      bad_instr = (funct3 != 3'd0);
    else if (is_reg)
      bad_instr = !((funct7 == 7'h00) || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
    else if (is_imm)
      bad_instr = (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20) ||
                  (funct3 == 3'd1 && funct7 != 7'h00);
    else if (!(is_jal || is_lui || is_auipc))
      bad_instr = 1'b1;
  end

  logic wait_tc;
  assign wait_tc = (wait_cnt == CW'(TIMEOUT - 1));

  // Strobes are decoded from state and the latched instruction; ir_we, store
  // retire and branch pc_sel also follow the same-cycle mem_ready/branch_taken.
  always_comb begin
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    pc_sel    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_size  = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op    = 4'd0;
    wb_sel    = 2'd0;
    retire    = 1'b0;
    if (st == S_DECODE || st == S_EXECUTE || st == S_MEMORY || st == S_WRITEBACK) begin
      if (is_reg)
        alu_op = {funct7[5], funct3};
      else if (is_imm)
        alu_op = {funct7[5] & (funct3 == 3'd5), funct3};
      if (is_lui) begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
      end else if (is_auipc || is_jal || is_branch) begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
      end else if (!is_reg) begin
        alu_src_b = 2'd1;
      end
    end
    case (st)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_size = 2'd2;
        ir_we    = mem_ready;
      end
      S_EXECUTE: begin
        if (is_branch) begin
          retire = 1'b1;
          pc_sel = branch_taken;
        end
      end
      S_MEMORY: begin
        mem_req  = 1'b1;
        mem_we   = is_store;
        mem_size = funct3[1:0];
        retire   = is_store & mem_ready;
      end
      S_WRITEBACK: begin
        retire = 1'b1;
        rf_we  = (rd != 5'd0);
        pc_sel = is_jal | is_jalr;
        if (is_jal || is_jalr)
          wb_sel = 2'd2;
        else if (is_load)
          wb_sel = 2'd1;
      end
      default: ;
    endcase
  end

  assign pc_we = retire;
  assign state = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      wait_cnt <= '0;
      instret  <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      wait_cnt <= '0;
      if (retire)
        instret <= instret + 32'd1;
      case (st)
        S_IDLE:
          if (start) st <= S_FETCH;
        S_FETCH, S_MEMORY: begin
          if (mem_ready) begin
            if (st == S_FETCH)
              st <= S_DECODE;
            else if (is_load)
              st <= S_WRITEBACK;
            else
              st <= start ? S_FETCH : S_IDLE;
          end else if (wait_tc) begin
            st      <= S_TRAP;
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          if (bad_instr) begin
            st      <= S_TRAP;
            illegal <= 1'b1;
          end else begin
            st <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (is_load || is_store)
            st <= S_MEMORY;
          else if (is_branch)
            st <= start ? S_FETCH : S_IDLE;
          else
            st <= S_WRITEBACK;
        end
        S_WRITEBACK:
          st <= start ? S_FETCH : S_IDLE;
        S_TRAP:
          st <= S_TRAP;
        default:
          st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: stimulus queues expected retire/trap
// events, a monitor checks them when the DUT retires or enters TRAP.
module tb_riscv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        mem_ready = 1'b1;
  logic        branch_taken = 1'b0;
  logic        ir_we, pc_we, rf_we, pc_sel, mem_req, mem_we, retire, illegal, timeout;
  logic [1:0]  mem_size, alu_src_a, alu_src_b, wb_sel;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] instret;

  riscv_multicycle_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
    .pc_sel(pc_sel), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .wb_sel(wb_sel),
    .state(state), .retire(retire), .instret(instret), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_trap;
    int          lat;
    logic        rf_we, pc_we, pc_sel;
    logic [1:0]  wb_sel, src_a, src_b;
    logic [3:0]  alu_op;
    logic [31:0] instret;
    logic        illegal, timeout;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_instret = 32'd0;
  logic [2:0]  prev_state = 3'd0;
  int          cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_ret(int lat, logic rf, logic ps, logic [1:0] wb,
                                  logic [1:0] a, logic [1:0] b, logic [3:0] op);
    exp_t e;
    e.is_trap = 1'b0; e.lat = lat; e.rf_we = rf; e.pc_we = 1'b1; e.pc_sel = ps;
    e.wb_sel = wb; e.src_a = a; e.src_b = b; e.alu_op = op; e.instret = 32'd0;
    e.illegal = 1'b0; e.timeout = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk_trap(int lat, logic ill, logic to);
    exp_t e;
    e = mk_ret(lat, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 4'd0);
    e.is_trap = 1'b1; e.pc_we = 1'b0; e.illegal = ill; e.timeout = to;
    return e;
  endfunction

  task automatic check_all_zero(input string name);
    logic [20:0] v;
    v = {ir_we, pc_we, rf_we, pc_sel, mem_req, mem_we, mem_size, alu_src_a, alu_src_b,
         alu_op, wb_sel, retire, illegal, timeout};
    chk({name, "_outs"}, 32'(v), 32'd0);
    chk({name, "_state"}, 32'(state), 32'd0);
    chk({name, "_instret"}, instret, 32'd0);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string name);
    int i = 0;
    while (state !== s && i < max) begin
      @(negedge clk);
      i++;
    end
    if (state !== s) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_%s: state actual=%0d expected=%0d", name, state, s);
    end
  endtask

  task automatic push(input exp_t e_in);
    exp_t e;
    e = e_in;
    e.instret = exp_instret;
    sb.push_back(e);
    if (!e.is_trap) exp_instret++;
  endtask

  // Called just after a negedge with the DUT in IDLE.
  task automatic issue(input logic [31:0] ins, input logic bt, input exp_t e);
    instr = ins;
    branch_taken = bt;
    push(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero(name);
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 32'd0;
    @(negedge clk);
  endtask

  // Monitor: samples 2 time units after the falling edge, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (state == 3'd1 && prev_state != 3'd1) cyc = 1;
      else cyc++;
      if (retire === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_retire: actual retire=1 expected=0 (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("retire_kind", 32'(e.is_trap), 32'd0);
          chk("retire_latency", 32'(cyc), 32'(e.lat));
          chk("retire_rf_we", 32'(rf_we), 32'(e.rf_we));
          chk("retire_pc_we", 32'(pc_we), 32'(e.pc_we));
          chk("retire_pc_sel", 32'(pc_sel), 32'(e.pc_sel));
          chk("retire_wb_sel", 32'(wb_sel), 32'(e.wb_sel));
          chk("retire_src_a", 32'(alu_src_a), 32'(e.src_a));
          chk("retire_src_b", 32'(alu_src_b), 32'(e.src_b));
          chk("retire_alu_op", 32'(alu_op), 32'(e.alu_op));
          chk("retire_instret", instret, e.instret);
        end
      end
      if (state == 3'd6 && prev_state != 3'd6) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_trap: actual state=6 expected no trap (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("trap_kind", 32'(e.is_trap), 32'd1);
          chk("trap_latency", 32'(cyc), 32'(e.lat));
          chk("trap_illegal", 32'(illegal), 32'(e.illegal));
          chk("trap_timeout", 32'(timeout), 32'(e.timeout));
          chk("trap_strobes", 32'({ir_we, pc_we, rf_we, mem_req, mem_we, retire}), 32'd0);
        end
      end
      prev_state = state;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // addi ra,zero,5
    issue(32'h00500093, 1'b0, mk_ret(4, 1, 0, 2'd0, 2'd0, 2'd1, 4'h0));
    wait_state(3'd0, 10, "addi");
    chk("addi_instret", instret, 32'd1);

    // sub x3,x1,x2
    issue(32'h402081B3, 1'b0, mk_ret(4, 1, 0, 2'd0, 2'd0, 2'd0, 4'h8));
    wait_state(3'd0, 10, "sub");
    // srai x5,x5,3
    issue(32'h4032D293, 1'b0, mk_ret(4, 1, 0, 2'd0, 2'd0, 2'd1, 4'hD));
    wait_state(3'd0, 10, "srai");
    // jal ra,8
    issue(32'h008000EF, 1'b0, mk_ret(4, 1, 1, 2'd2, 2'd1, 2'd1, 4'h0));
    wait_state(3'd0, 10, "jal");
    // lui x0,1: rd=0 so no register write
    issue(32'h00001037, 1'b0, mk_ret(4, 0, 0, 2'd0, 2'd2, 2'd1, 4'h0));
    wait_state(3'd0, 10, "lui");
    // beq taken / not taken
    issue(32'h00000463, 1'b1, mk_ret(3, 0, 1, 2'd0, 2'd1, 2'd1, 4'h0));
    wait_state(3'd0, 10, "beq_t");
    issue(32'h00000463, 1'b0, mk_ret(3, 0, 0, 2'd0, 2'd1, 2'd1, 4'h0));
    wait_state(3'd0, 10, "beq_nt");
    // sw x2,4(x1)
    issue(32'h0020A223, 1'b0, mk_ret(4, 0, 0, 2'd0, 2'd0, 2'd1, 4'h0));
    wait_state(3'd0, 10, "sw");

    // lw sp,0(ra) with three MEMORY cycles of mem_ready=0
    issue(32'h0000A103, 1'b0, mk_ret(8, 1, 0, 2'd1, 2'd0, 2'd1, 4'h0));
    wait_state(3'd3, 5, "lw_exec");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lw_wait_state", 32'(state), 32'd4);
      chk("lw_wait_size", 32'(mem_size), 32'd2);
      chk("lw_wait_req", 32'({mem_req, mem_we}), 32'b10);
    end
    @(negedge clk);
    chk("lw_ready_size", 32'(mem_size), 32'd2);
    mem_ready = 1'b1;
    wait_state(3'd0, 10, "lw");
    chk("lw_instret", instret, 32'd9);

    // Two addi back to back with start held through the first retire
    instr = 32'h00500093;
    push(mk_ret(4, 1, 0, 2'd0, 2'd0, 2'd1, 4'h0));
    push(mk_ret(4, 1, 0, 2'd0, 2'd0, 2'd1, 4'h0));
    start = 1'b1;
    @(negedge clk);
    wait_state(3'd5, 10, "b2b_wb");
    @(negedge clk);
    chk("b2b_refetch", 32'(state), 32'd1);
    start = 1'b0;
    wait_state(3'd0, 10, "b2b");
    chk("b2b_instret", instret, 32'd11);

    // Illegal load (funct3=3): TRAP is absorbing even with start held
    issue(32'h0000B003, 1'b0, mk_trap(3, 1, 0));
    wait_state(3'd6, 10, "ill_ld");
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("trap_hold_state", 32'(state), 32'd6);
      chk("trap_hold_instret", instret, 32'd11);
    end
    start = 1'b0;
    do_reset("ill_reset");

    // Illegal ARITH_REG: funct7=0x20 with funct3=1
    issue(32'h40001033, 1'b0, mk_trap(3, 1, 0));
    wait_state(3'd6, 10, "ill_reg");
    do_reset("ill2_reset");

    // mem_ready held low in FETCH
    mem_ready = 1'b0;
    issue(32'h00500093, 1'b0, mk_trap(16, 0, 1));
    wait_state(3'd6, 30, "tmo");
    chk("tmo_sticky", 32'({timeout, illegal}), 32'b10);
    mem_ready = 1'b1;
    do_reset("tmo_reset");

    // Reset asserted while a store waits in MEMORY
    instr = 32'h0020A223;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state(3'd3, 5, "rst_exec");
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_state", 32'(state), 32'd4);
    chk("rst_mem_req", 32'({mem_req, mem_we}), 32'b11);
    #3 rst_n = 1'b0;
    #1 check_all_zero("mid_mem_reset");
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 32'd0;
    @(negedge clk);

    // Counter restarts from zero after reset
    issue(32'h00500093, 1'b0, mk_ret(4, 1, 0, 2'd0, 2'd0, 2'd1, 4'h0));
    wait_state(3'd0, 10, "post_rst");
    chk("post_rst_instret", instret, 32'd1);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
RISCV_MULTICYCLE_CTRL -- requirements
Module: riscv_multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max cycles a memory request waits for mem_ready before trapping.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  run enable; sampled in IDLE and at retire.
REQ-005 SHALL have port instr  input  32  instruction register contents, valid from DECODE onward.
REQ-006 SHALL have port mem_ready  input  1  memory completes the current request this cycle.
REQ-007 SHALL have port branch_taken  input  1  external comparator result, valid in EXECUTE.
REQ-008 SHALL have port ir_we, pc_we, rf_we  output  1 each  IR / PC / register-file write strobes.
REQ-009 SHALL have port pc_sel  output  1  next-PC select: 0 = pc+4, 1 = ALU result.
REQ-010 SHALL have port mem_req, mem_we  output  1 each  memory request; 1 = store.
REQ-011 SHALL have port mem_size  output  2  access size: 0 = byte, 1 = half, 2 = word; equals funct3[1:0] in MEMORY, 2 in FETCH.
REQ-012 SHALL have port alu_src_a  output  2  ALU A select: 0 = rs1, 1 = pc, 2 = zero.
REQ-013 SHALL have port alu_src_b  output  2  ALU B select: 0 = rs2, 1 = imm.
REQ-014 SHALL have port alu_op  output  4  ALU operation.
REQ-015 SHALL have port wb_sel  output  2  writeback select: 0 = ALU, 1 = load data, 2 = pc+4.
REQ-016 SHALL have port state  output  3  current state: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, TRAP=6.
REQ-017 SHALL have port retire  output  1  one-cycle pulse when an instruction completes.
REQ-018 SHALL have port instret  output  32  retired-instruction count.
REQ-019 SHALL have port illegal, timeout  output  1 each  sticky trap causes.

Function
REQ-020 SHALL decode only the opcodes ARITH_REG, ARITH_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC; any other opcode is illegal.
REQ-021 SHALL treat as illegal: LOAD funct3 3/6/7; STORE funct3 >2; BRANCH funct3 2/3; JALR funct3 != 0; ARITH_REG funct7 not 0x00/0x20, or 0x20 with funct3 not 0/5; ARITH_IMM funct3 5 with imm[11:5] not 0x00/0x20; ARITH_IMM funct3 1 with imm[11:5] != 0.
REQ-022 SHALL use transition IDLE -> FETCH when start=1.
REQ-023 SHALL drive mem_req=1, mem_we=0 in FETCH; on mem_ready, pulse ir_we and go to DECODE.
REQ-024 SHALL go DECODE -> TRAP (illegal=1) on an illegal instruction; otherwise DECODE -> EXECUTE.
REQ-025 SHALL use these EXECUTE exits:
- LOAD/STORE -> MEMORY.
- BRANCH -> retire, pc_we=1, pc_sel=branch_taken.
- All other opcodes -> WRITEBACK.
REQ-026 SHALL drive mem_req=1, mem_we=1 for STORE in MEMORY; on mem_ready, LOAD -> WRITEBACK and STORE retires with pc_we=1, pc_sel=0.
REQ-027 SHALL in WRITEBACK drive rf_we=1 unless rd=0, drive pc_we=1, and retire.
- pc_sel=1 for JAL/JALR, else 0.
- wb_sel=2 for JAL/JALR, 1 for LOAD, else 0.
REQ-028 SHALL go to FETCH at retire if start=1, else to IDLE.
REQ-029 SHALL set alu_op to {funct7[5], funct3} for ARITH_REG and to {imm[10]&(funct3==5), funct3} for ARITH_IMM; every other opcode uses ADD (0000).
REQ-030 SHALL set the ALU operand selects as follows (alu_src_a, alu_src_b):
- LUI: (2, 1).
- AUIPC/JAL/BRANCH: (1, 1).
- ARITH_REG: (0, 0).
- All others: (0, 1).
REQ-031 SHALL keep a wait counter that clears on entry to FETCH/MEMORY and increments each cycle while mem_req=1 and mem_ready=0; reaching TIMEOUT goes to TRAP with timeout=1 and no strobes.
REQ-032 SHALL give the wait counter priority to mem_ready when both occur in the same cycle.
REQ-033 SHALL keep TRAP absorbing, with all strobes 0, until reset.
REQ-034 SHALL increment instret on each retire and wrap modulo 2^32.
REQ-035 SHALL keep strobe and select outputs Moore-decoded from state and latched instruction fields; only ir_we/pc_we/rf_we/retire may be 1 for a single cycle per visit.
REQ-036 SHALL achieve latency with mem_ready tied high: ALU/JAL/JALR/LUI/AUIPC 4 cycles, LOAD 5, STORE 4, BRANCH 3, start to first fetch 1.

Reset
REQ-037 SHALL on rst_n=0 immediately set state=IDLE, clear instret, counter, illegal and timeout, and drive all strobes, selects and alu_op to 0, regardless of state or pending memory request.

Verification
REQ-038 SHALL cover: start=1, mem_ready=1, instr=0x00500093 (addi ra,zero,5) -> rf_we at cycle 4, alu_src_b=1, retire, instret=1.
REQ-039 SHALL cover: instr=0x0000A103 (lw sp,0(ra)), mem_ready delayed 3 cycles in MEMORY -> mem_size=2 held, rf_we and wb_sel=1 one cycle after mem_ready.
REQ-040 SHALL cover: beq taken (0x00000463) with branch_taken=1 -> pc_we=1, pc_sel=1 at cycle 3, no rf_we.
REQ-041 SHALL cover: instr=0x0000B003 (funct3=3 load) -> TRAP, illegal=1, no retire until reset.
REQ-042 SHALL cover: mem_ready held 0 in FETCH -> TRAP, timeout=1 after exactly TIMEOUT cycles; rst_n pulse mid-MEMORY -> IDLE, all outputs 0.
